// File: rtl/di_tx_sched.sv
// rtl/di_tx_sched.sv - UART transmit scheduler for time reports and the optional alarm message.
// Alarm edge detection, its request latch and the "ALARM\r\n" message exist only with DI_TX_ALARM_MSG_EN.
module di_tx_sched #(
  parameter int MSG_LEN = 7,
  parameter int GAP_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       oneSecStrb,
  input  logic       dicRun,
  input  logic       dicAlarmTrig,
  input  logic [3:0] di_Mtens,
  input  logic [3:0] di_Mones,
  input  logic [3:0] di_Stens,
  input  logic [3:0] di_Sones,
  input  logic       bu_tx_busy,
  output logic       L3_tx_data_rdy,
  output logic [7:0] L3_tx_data,
  output logic       di_txDrop,
  output logic       di_txBusy
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  localparam logic [2:0] LAST_IDX = 3'(MSG_LEN - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 2);

  state_t     state, state_nxt;
  logic       time_req;
  logic       time_ev;
  logic       pending;
  logic       grant_time;
  logic       send;
  logic [2:0] idx;
  logic [7:0] gap_cnt;
  logic [7:0] data_q;
  logic [7:0] time_byte;
  logic [7:0] cur_byte;
  logic [3:0] snap_mt, snap_mo, snap_st, snap_so;

  assign time_ev = oneSecStrb & dicRun;

`ifdef DI_TX_ALARM_MSG_EN
  logic       alarm_req;
  logic       trig_q;
  logic       alarm_edge;
  logic       grant_alarm;
  logic       msg_alarm;
  logic [7:0] alarm_byte;

  assign alarm_edge  = dicAlarmTrig & ~trig_q;
  assign pending     = alarm_req | time_req;
  assign grant_alarm = (state == IDLE) & alarm_req;
  assign grant_time  = (state == IDLE) & ~alarm_req & time_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_req <= 1'b0;
      trig_q    <= 1'b0;
      msg_alarm <= 1'b0;
    end else begin
      trig_q <= dicAlarmTrig;
      if (alarm_edge)
        alarm_req <= 1'b1;
      else if (grant_alarm)
        alarm_req <= 1'b0;
      if (state == IDLE && pending)
        msg_alarm <= alarm_req;
    end
  end

  always_comb begin
    alarm_byte = 8'h0A;
    case (idx)
      3'd0: alarm_byte = 8'h41;
      3'd1: alarm_byte = 8'h4C;
      3'd2: alarm_byte = 8'h41;
      3'd3: alarm_byte = 8'h52;
      3'd4: alarm_byte = 8'h4D;
      3'd5: alarm_byte = 8'h0D;
      default: alarm_byte = 8'h0A;
    endcase
  end

  assign cur_byte = msg_alarm ? alarm_byte : time_byte;
`else
  logic unused_trig;
  assign unused_trig = dicAlarmTrig;
  assign pending     = time_req;
  assign grant_time  = (state == IDLE) & time_req;
  assign cur_byte    = time_byte;
`endif

  // Digits above 9 pass straight through as 0x30|d.
  always_comb begin
    time_byte = 8'h0A;
    case (idx)
      3'd0: time_byte = 8'h30 | {4'h0, snap_mt};
      3'd1: time_byte = 8'h30 | {4'h0, snap_mo};
      3'd2: time_byte = 8'h3A;
      3'd3: time_byte = 8'h30 | {4'h0, snap_st};
      3'd4: time_byte = 8'h30 | {4'h0, snap_so};
      3'd5: time_byte = 8'h0D;
      default: time_byte = 8'h0A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (pending) state_nxt = LOAD;
      LOAD: state_nxt = SEND;
      SEND: if (!bu_tx_busy) state_nxt = GAP;
      GAP: begin
        if (gap_cnt == GAP_LAST)
          state_nxt = (idx == LAST_IDX) ? IDLE : SEND;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    send           = (state == SEND) & ~bu_tx_busy;
    L3_tx_data_rdy = send;
    L3_tx_data     = send ? cur_byte : data_q;
    di_txBusy      = (state != IDLE);
  end

  // A strobe landing in the grant cycle re-arms the latch instead of counting as an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      time_req  <= 1'b0;
      di_txDrop <= 1'b0;
      idx       <= 3'd0;
      gap_cnt   <= 8'd0;
      data_q    <= 8'h00;
      snap_mt   <= 4'd0;
      snap_mo   <= 4'd0;
      snap_st   <= 4'd0;
      snap_so   <= 4'd0;
    end else begin
      di_txDrop <= time_ev & time_req & ~grant_time;
      if (time_ev)
        time_req <= 1'b1;
      else if (grant_time)
        time_req <= 1'b0;
      if (state == LOAD) begin
        idx     <= 3'd0;
        snap_mt <= di_Mtens;
        snap_mo <= di_Mones;
        snap_st <= di_Stens;
        snap_so <= di_Sones;
      end
      if (send) begin
        data_q  <= cur_byte;
        gap_cnt <= 8'd0;
      end
      if (state == GAP) begin
        if (gap_cnt == GAP_LAST) begin
          if (idx != LAST_IDX)
            idx <= idx + 3'd1;
        end else begin
          gap_cnt <= gap_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_di_tx_sched.sv
// tb/tb_di_tx_sched.sv - directed bench for di_tx_sched; alarm priority case only with DI_TX_ALARM_MSG_EN.
module tb_di_tx_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       oneSecStrb;
  logic       dicRun;
  logic       dicAlarmTrig;
  logic [3:0] di_Mtens, di_Mones, di_Stens, di_Sones;
  logic       bu_tx_busy;
  logic       L3_tx_data_rdy;
  logic [7:0] L3_tx_data;
  logic       di_txDrop;
  logic       di_txBusy;

  di_tx_sched #(.MSG_LEN(7), .GAP_CYC(2)) dut (
    .clk(clk), .rst(rst), .oneSecStrb(oneSecStrb), .dicRun(dicRun),
    .dicAlarmTrig(dicAlarmTrig), .di_Mtens(di_Mtens), .di_Mones(di_Mones),
    .di_Stens(di_Stens), .di_Sones(di_Sones), .bu_tx_busy(bu_tx_busy),
    .L3_tx_data_rdy(L3_tx_data_rdy), .L3_tx_data(L3_tx_data),
    .di_txDrop(di_txDrop), .di_txBusy(di_txBusy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] byte_q[$];
  int         cyc_q[$];
  logic [7:0] exp_q[$];
  int drop_cnt = 0;
  int busy_viol = 0;

  // Outputs are sampled mid-cycle; inputs change 2 time units after the rising edge.
  always @(negedge clk) begin
    if (L3_tx_data_rdy === 1'b1) begin
      byte_q.push_back(L3_tx_data);
      cyc_q.push_back(cyc);
      if (bu_tx_busy) busy_viol++;
    end
    if (di_txDrop === 1'b1) drop_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic strobe();
    oneSecStrb = 1'b1;
    tick(1);
    oneSecStrb = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int max);
    for (int i = 0; i < max && byte_q.size() < n; i++) tick(1);
  endtask

  task automatic set_digits(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    di_Mtens = a; di_Mones = b; di_Stens = c; di_Sones = d;
  endtask

  task automatic push_time(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    exp_q.push_back(8'h30 | {4'h0, a});
    exp_q.push_back(8'h30 | {4'h0, b});
    exp_q.push_back(8'h3A);
    exp_q.push_back(8'h30 | {4'h0, c});
    exp_q.push_back(8'h30 | {4'h0, d});
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic clear();
    byte_q.delete();
    cyc_q.delete();
    exp_q.delete();
    drop_cnt = 0;
  endtask

  task automatic check_msgs(input string tag);
    logic [31:0] got;
    check({tag, " count"}, byte_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < byte_q.size()) ? {24'h0, byte_q[i]} : 32'hxxxxxxxx;
      check($sformatf("%s byte%0d", tag, i), got, {24'h0, exp_q[i]});
    end
  endtask

  function automatic logic [31:0] cyc_at(input int i);
    return (i < cyc_q.size()) ? cyc_q[i] : 32'hffffffff;
  endfunction

  initial begin
    int k;
    int rel;
    int n_rel;
    rst = 1'b1; oneSecStrb = 1'b0; dicRun = 1'b1; dicAlarmTrig = 1'b0; bu_tx_busy = 1'b0;
    set_digits(0, 0, 0, 0);
    tick(3);
    rst = 1'b0;
    check("reset rdy", L3_tx_data_rdy, 0);
    check("reset data", L3_tx_data, 8'h00);
    check("reset drop", di_txDrop, 0);
    check("reset busy", di_txBusy, 0);

    // basic time report
    clear();
    set_digits(1, 2, 3, 4);
    k = cyc;
    strobe();
    wait_bytes(7, 40);
    tick(4);
    push_time(1, 2, 3, 4);
    check_msgs("time");
    for (int i = 0; i < 7; i++) check($sformatf("time cyc%0d", i), cyc_at(i) - k, 3 + 2 * i);
    check("time idle busy", di_txBusy, 0);

    // back-pressure after the third byte
    clear();
    set_digits(5, 9, 0, 7);
    strobe();
    wait_bytes(3, 40);
    bu_tx_busy = 1'b1;
    tick(10);
    bu_tx_busy = 1'b0;
    rel = cyc;
    n_rel = byte_q.size();
    wait_bytes(7, 40);
    tick(4);
    check("bp bytes during hold", n_rel, 3);
    check("bp fourth cyc", cyc_at(3), rel);
    check("bp busy violations", busy_viol, 0);
    push_time(5, 9, 0, 7);
    check_msgs("bp");

    // overrun: second strobe queued, third dropped; digits change mid-message
    clear();
    set_digits(2, 3, 5, 9);
    k = cyc;
    strobe();
    tick(4);
    strobe();
    tick(2);
    strobe();
    set_digits(4, 5, 1, 1);
    wait_bytes(14, 80);
    tick(6);
    push_time(2, 3, 5, 9);
    push_time(4, 5, 1, 1);
    check_msgs("ovr");
    check("ovr drop pulses", drop_cnt, 1);
    check("ovr last byte msg1", cyc_at(6) - k, 15);
    check("ovr first byte msg2", cyc_at(7) - k, 19);

    // reset mid-message with a pending request
    clear();
    set_digits(1, 2, 3, 4);
    strobe();
    wait_bytes(1, 20);
    strobe();
    wait_bytes(2, 20);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst rdy", L3_tx_data_rdy, 0);
    check("rst data", L3_tx_data, 8'h00);
    check("rst busy", di_txBusy, 0);
    tick(40);
    check("rst no more bytes", byte_q.size(), 2);

    // dicRun low suppresses requests
    clear();
    dicRun = 1'b0;
    strobe();
    tick(20);
    dicRun = 1'b1;
    check("norun bytes", byte_q.size(), 0);

`ifdef DI_TX_ALARM_MSG_EN
    // alarm edge and strobe together: alarm first, then time from its own snapshot
    clear();
    set_digits(1, 2, 3, 4);
    k = cyc;
    dicAlarmTrig = 1'b1;
    strobe();
    tick(5);
    set_digits(0, 9, 5, 8);
    wait_bytes(14, 80);
    tick(4);
    dicAlarmTrig = 1'b0;
    exp_q.push_back(8'h41); exp_q.push_back(8'h4C); exp_q.push_back(8'h41);
    exp_q.push_back(8'h52); exp_q.push_back(8'h4D); exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    push_time(0, 9, 5, 8);
    check_msgs("prio");
    check("prio first cyc", cyc_at(0) - k, 3);
    check("prio time cyc", cyc_at(7) - k, 19);
`else
    // alarm input ignored; time report unaffected and not aborted by dicRun low
    clear();
    dicAlarmTrig = 1'b1;
    tick(3);
    dicAlarmTrig = 1'b0;
    tick(3);
    dicAlarmTrig = 1'b1;
    tick(20);
    dicAlarmTrig = 1'b0;
    check("noalarm bytes", byte_q.size(), 0);
    set_digits(0, 0, 5, 9);
    strobe();
    wait_bytes(1, 20);
    dicRun = 1'b0;
    wait_bytes(7, 40);
    dicRun = 1'b1;
    tick(4);
    push_time(0, 0, 5, 9);
    check_msgs("noalarm time");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
